// File: rtl/hwpe_ctrl_vfpu_package.sv
// Shared widths, constants and result/flag types for the vfpu datapath.
package hwpe_ctrl_vfpu_package;

  localparam int FP_EXP_WIDTH          = 8;
  localparam int FP_MANT_WIDTH         = 23;
  localparam int FP_EXP_PRENORM_WIDTH  = 10;
  localparam int FP_MANT_PRENORM_WIDTH = 48;

  localparam logic [FP_EXP_WIDTH-1:0] FP_EXP_INF = 8'hFF;
  localparam int                      FP_BIAS    = 127;

  typedef struct packed {
    logic                     sign;
    logic [FP_EXP_WIDTH-1:0]  exponent;
    logic [FP_MANT_WIDTH-1:0] mantissa;
  } fp32_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } vfpu_flags_t;

endpackage

// File: rtl/vfpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module vfpu_lzc #(
  parameter int WIDTH = 48,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count,
  output logic             isZero
);

  // Scan upward so the most significant set bit is the last assignment to win.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign isZero = ~|data;

endmodule

// File: rtl/vfpu_norm_round.sv
// Normalise / round-to-nearest-even / pack stage, 3-deep pipeline with valid/ready.
// Optional macro VFPU_NORM_FLAGS_EN adds flags_o = {overflow, underflow, inexact}.
module vfpu_norm_round
  import hwpe_ctrl_vfpu_package::*;
#(
  parameter int EXP_W      = FP_EXP_WIDTH,
  parameter int MANT_W     = FP_MANT_WIDTH,
  parameter int PRE_EXP_W  = FP_EXP_PRENORM_WIDTH,
  parameter int PRE_MANT_W = FP_MANT_PRENORM_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        signPreNorm_i,
  input  logic signed [PRE_EXP_W-1:0] exponentPreNorm_i,
  input  logic [PRE_MANT_W-1:0]       mantissaPreNorm_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [EXP_W+MANT_W:0]       result_o,
`ifdef VFPU_NORM_FLAGS_EN
  output logic [2:0]                  flags_o,
`endif
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int CNT_W = $clog2(PRE_MANT_W + 1);
  localparam int XE_W  = PRE_EXP_W + 1;
  localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

  logic en;
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  // Stage 1: leading-zero count
  logic [CNT_W-1:0] lzcIn;
  logic             zeroIn;

  vfpu_lzc #(.WIDTH(PRE_MANT_W), .CNT_W(CNT_W)) uLzc (
    .data   (mantissaPreNorm_i),
    .count  (lzcIn),
    .isZero (zeroIn)
  );

  logic                        s1Valid, s1Sign, s1Zero;
  logic signed [PRE_EXP_W-1:0] s1Exp;
  logic [PRE_MANT_W-1:0]       s1Mant;
  logic [CNT_W-1:0]            s1Lzc;

  // Stage 2: shift and extract round bits
  logic [PRE_MANT_W-1:0] norm;
  logic signed [XE_W-1:0] expNorm;

  assign norm    = s1Mant << s1Lzc;
  assign expNorm = $signed({s1Exp[PRE_EXP_W-1], s1Exp})
                 + $signed({{PRE_EXP_W{1'b0}}, 1'b1})
                 - $signed({{(XE_W-CNT_W){1'b0}}, s1Lzc});

  logic                   s2Valid, s2Sign, s2Zero, s2G, s2R, s2S;
  logic signed [XE_W-1:0] s2Exp;
  logic [MANT_W-1:0]      s2Frac;

  // Stage 3: round and pack
  logic                   inc, carry, isOvf, isUnf;
  logic [MANT_W-1:0]      fracR;
  logic signed [XE_W-1:0] expR;
  logic [EXP_W+MANT_W:0]  packed3;
  vfpu_flags_t            flags3;

  always_comb begin
    inc     = s2G & (s2R | s2S | s2Frac[0]);
    // All-ones fraction plus increment wraps to zero and bumps the exponent.
    carry   = inc & (&s2Frac);
    fracR   = s2Frac + {{(MANT_W-1){1'b0}}, inc};
    expR    = s2Exp + $signed({{PRE_EXP_W{1'b0}}, carry});
    isOvf   = 1'b0;
    isUnf   = 1'b0;
    packed3 = '0;
    if (s2Zero) begin
      packed3 = '0;
    end else if (expR >= EXP_MAX) begin
      isOvf   = 1'b1;
      packed3 = {s2Sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (expR <= $signed(XE_W'(0))) begin
      isUnf   = 1'b1;
      packed3 = {s2Sign, {(EXP_W+MANT_W){1'b0}}};
    end else begin
      packed3 = {s2Sign, expR[EXP_W-1:0], fracR};
    end
    flags3.overflow  = isOvf;
    flags3.underflow = isUnf;
    flags3.inexact   = s2G | s2R | s2S | isOvf | isUnf;
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      s1Sign <= signPreNorm_i;
      s1Exp  <= exponentPreNorm_i;
      s1Mant <= mantissaPreNorm_i;
      s1Lzc  <= lzcIn;
      s1Zero <= zeroIn;
      s2Sign <= s1Sign;
      s2Zero <= s1Zero;
      s2Exp  <= expNorm;
      s2Frac <= norm[PRE_MANT_W-2 -: MANT_W];
      s2G    <= norm[PRE_MANT_W-2-MANT_W];
      s2R    <= norm[PRE_MANT_W-3-MANT_W];
      s2S    <= |norm[PRE_MANT_W-4-MANT_W:0];
    end
  end

`ifdef VFPU_NORM_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)   flags_o <= '0;
    else if (en) flags_o <= flags3;
  end
`else
  vfpu_flags_t flagsUnused;
  assign flagsUnused = flags3;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid  <= 1'b0;
      s2Valid  <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else if (en) begin
      s1Valid  <= valid_i;
      s2Valid  <= s1Valid;
      valid_o  <= s2Valid;
      result_o <= packed3;
    end
  end

endmodule

// File: tb/tb_vfpu_norm_round.sv
// Directed bench for vfpu_norm_round: rounding/packing vectors, stall and reset behaviour.
module tb_vfpu_norm_round;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        signPreNorm_i;
  logic [9:0]  exponentPreNorm_i;
  logic [47:0] mantissaPreNorm_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] result_o;
  logic        valid_o;
  logic        ready_i;
`ifdef VFPU_NORM_FLAGS_EN
  logic [2:0]  flags_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic        bpSign [5];
  logic [9:0]  bpExp  [5];
  logic [47:0] bpMant [5];
  logic [31:0] bpRes  [5];

  vfpu_norm_round dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .signPreNorm_i     (signPreNorm_i),
    .exponentPreNorm_i (exponentPreNorm_i),
    .mantissaPreNorm_i (mantissaPreNorm_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .result_o          (result_o),
`ifdef VFPU_NORM_FLAGS_EN
    .flags_o           (flags_o),
`endif
    .valid_o           (valid_o),
    .ready_i           (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated beat: accept, then valid_o must rise exactly on the third cycle.
  task automatic runVec(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input logic [31:0] expRes, input logic [2:0] expFl);
    @(negedge clk_i);
    signPreNorm_i = s; exponentPreNorm_i = e; mantissaPreNorm_i = m; valid_i = 1'b1;
    #1 check({tag, "_rdy"}, 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check({tag, "_lat1"}, 32'(valid_o), 32'd0);
    @(negedge clk_i);
    check({tag, "_lat2"}, 32'(valid_o), 32'd0);
    @(negedge clk_i);
    check({tag, "_vld"}, 32'(valid_o), 32'd1);
    check({tag, "_res"}, result_o, expRes);
`ifdef VFPU_NORM_FLAGS_EN
    check({tag, "_flg"}, 32'(flags_o), 32'(expFl));
`else
    if (expFl === 3'bxxx) $display("unreachable");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    signPreNorm_i = 1'b0; exponentPreNorm_i = '0; mantissaPreNorm_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    rst_i = 1'b0;

    runVec("one_plus_one", 1'b0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 3'b000);
    runVec("exact_ones",   1'b0, 10'd127, 48'h7FFF_FF80_0000, 32'h3FFF_FFFF, 3'b000);
    runVec("round_carry",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001);
    runVec("tie_even",     1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001);
    runVec("round_up",     1'b1, 10'd127, 48'h4000_0060_0000, 32'hBF80_0001, 3'b001);
    runVec("twenty_four",  1'b0, 10'd130, 48'hC000_0000_0000, 32'h41C0_0000, 3'b000);
    runVec("overflow",     1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b101);
    runVec("carry_to_inf", 1'b1, 10'd254, 48'h7FFF_FFC0_0000, 32'hFF80_0000, 3'b101);
    runVec("carry_to_max", 1'b0, 10'd253, 48'h7FFF_FFC0_0000, 32'h7F00_0000, 3'b001);
    runVec("underflow",    1'b1, 10'd1,   48'h2000_0000_0000, 32'h8000_0000, 3'b011);
    runVec("min_normal",   1'b0, 10'd0,   48'h8000_0000_0000, 32'h0080_0000, 3'b000);
    runVec("neg_exp_ftz",  1'b0, 10'h3FF, 48'h8000_0000_0000, 32'h0000_0000, 3'b011);
    runVec("zero",         1'b1, 10'd130, 48'h0,              32'h0000_0000, 3'b000);

    // Back-pressure: five back-to-back beats, consumer stalls 4 cycles on first result.
    bpSign[0] = 1'b0; bpExp[0] = 10'd127; bpMant[0] = 48'h8000_0000_0000; bpRes[0] = 32'h4000_0000;
    bpSign[1] = 1'b0; bpExp[1] = 10'd127; bpMant[1] = 48'h4000_0000_0000; bpRes[1] = 32'h3F80_0000;
    bpSign[2] = 1'b1; bpExp[2] = 10'd130; bpMant[2] = 48'hC000_0000_0000; bpRes[2] = 32'hC1C0_0000;
    bpSign[3] = 1'b0; bpExp[3] = 10'd127; bpMant[3] = 48'h4000_0060_0000; bpRes[3] = 32'h3F80_0001;
    bpSign[4] = 1'b1; bpExp[4] = 10'd1;   bpMant[4] = 48'h2000_0000_0000; bpRes[4] = 32'h8000_0000;
    begin
      int idx = 0;
      int got = 0;
      int stall = 0;
      bit stallDone = 1'b0;
      logic [31:0] held = '0;
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
        @(negedge clk_i);
        if (valid_o && !stallDone) begin
          stall = 4; stallDone = 1'b1; held = result_o;
        end
        ready_i = (stall == 0);
        if (idx < 5) begin
          signPreNorm_i = bpSign[idx]; exponentPreNorm_i = bpExp[idx];
          mantissaPreNorm_i = bpMant[idx]; valid_i = 1'b1;
        end else begin
          valid_i = 1'b0;
        end
        #1;
        if (stall > 0) begin
          check("bp_ready_low", 32'(ready_o), 32'd0);
          check("bp_hold_res", result_o, held);
          check("bp_hold_vld", 32'(valid_o), 32'd1);
          stall--;
        end
        if (valid_o && ready_i) begin
          check("bp_order", result_o, bpRes[got]);
          got++;
        end
        if (valid_i && ready_o) idx++;
      end
      check("bp_count", 32'(got), 32'd5);
      check("bp_stalled", 32'(stallDone), 32'd1);
      valid_i = 1'b0; ready_i = 1'b1;
      repeat (3) begin
        @(negedge clk_i);
        check("bp_no_dup", 32'(valid_o), 32'd0);
      end
    end

    // Reset with three beats in flight.
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      signPreNorm_i = 1'b0; exponentPreNorm_i = 10'd127;
      mantissaPreNorm_i = 48'h8000_0000_0000; valid_i = 1'b1;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    check("pre_rst_vld", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd1);
    repeat (5) begin
      @(negedge clk_i);
      check("midrst_no_stale", 32'(valid_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
